ysyx_23060072_lsu_stage: RTL and testbench

YSYX_23060072_LSU_STAGE -- requirements
Module: ysyx_23060072_lsu_stage

---
 rtl/ysyx_23060072_lsu_stage.sv | 117 +++++++++++
 tb/tb_ysyx_23060072_lsu_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060072_lsu_stage.sv
// ysyx_23060072_lsu_stage: load/store stage with a request/grant/rvalid bus and a one-cycle write-back pulse
module ysyx_23060072_lsu_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] pc_i,
    input  logic        wb_en_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] result_i,
    input  logic [31:0] store_data_i,
    input  logic [1:0]  mem_op_i,
    input  logic [2:0]  funct3_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_flag_o,
    output logic [31:0] pc_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state, state_n;
    logic        accept, is_mem, is_store, bad_f3, misal, fault, go;
    logic [1:0]  off;
    logic [3:0]  st_strb;
    logic [31:0] st_data, shifted, ld_data;
    logic [31:0] pc_q;
    logic [4:0]  wb_addr_q;
    logic        wb_en_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    assign ready_o  = (state == IDLE) && !rst;
    assign accept   = valid_i && ready_o;
    assign off      = result_i[1:0];
    assign is_mem   = mem_op_i[0] ^ mem_op_i[1];
    assign is_store = mem_op_i == 2'b10;
    assign bad_f3   = funct3_i == 3'b011 || funct3_i[2:1] == 2'b11 || (is_store && funct3_i[2]);
    assign misal    = (funct3_i[1:0] == 2'b01 && off[0]) || (funct3_i == 3'b010 && off != 2'b00);
    assign fault    = mem_op_i == 2'b11 || (is_mem && (bad_f3 || misal));
    assign go       = accept && is_mem && !fault;
    assign st_strb  = funct3_i[1:0] == 2'b00 ? 4'b0001 << off :
                      funct3_i[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    assign st_data  = funct3_i[1:0] == 2'b00 ? {4{store_data_i[7:0]}} :
                      funct3_i[1:0] == 2'b01 ? {2{store_data_i[15:0]}} : store_data_i;
    assign shifted  = mem_rdata_i >> {off_q, 3'b000};
    assign ld_data  = funct3_q[1] ? mem_rdata_i :
                      funct3_q[0] ? {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]} :
                                    {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]};
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    // next state: stores retire on grant (posted), loads wait for read data
    always_comb begin
        state_n = state;
        if (state == IDLE && go)           state_n = REQ;
        if (state == REQ && mem_gnt_i)     state_n = mem_we_o ? IDLE : WAIT;
        if (state == WAIT && mem_rvalid_i) state_n = IDLE;
    end
    // bus request, operand capture and write-back/error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wstrb_o <= 4'd0;
            mem_wdata_o <= 32'd0;
            wb_flag_o   <= 1'b0;
            err_o       <= 1'b0;
            pc_o        <= 32'd0;
            wb_addr_o   <= 5'd0;
            wb_data_o   <= 32'd0;
            pc_q        <= 32'd0;
            wb_addr_q   <= 5'd0;
            wb_en_q     <= 1'b0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
        end else begin
            wb_flag_o <= 1'b0;
            err_o     <= 1'b0;
            if (accept && mem_op_i == 2'b00) begin
                pc_o      <= pc_i;
                wb_addr_o <= wb_addr_i;
                wb_data_o <= result_i;
                wb_flag_o <= wb_en_i && wb_addr_i != 5'd0;
            end
            if (accept && fault) err_o <= 1'b1;
            if (go) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= is_store;
                mem_addr_o  <= {result_i[31:2], 2'b00};
                mem_wstrb_o <= is_store ? st_strb : 4'b0000;
                mem_wdata_o <= is_store ? st_data : 32'd0;
                pc_q        <= pc_i;
                wb_addr_q   <= wb_addr_i;
                wb_en_q     <= wb_en_i && wb_addr_i != 5'd0;
                funct3_q    <= funct3_i;
                off_q       <= off;
            end
            if (state == REQ && mem_gnt_i) mem_req_o <= 1'b0;
            if (state == WAIT && mem_rvalid_i) begin
                pc_o      <= pc_q;
                wb_addr_o <= wb_addr_q;
                wb_data_o <= ld_data;
                wb_flag_o <= wb_en_q;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060072_lsu_stage.sv
// tb_ysyx_23060072_lsu_stage: directed checks of the load/store stage
module tb_ysyx_23060072_lsu_stage;
    logic        clk = 1'b0;
    logic        rst, valid_i, ready_o, wb_en_i;
    logic [31:0] pc_i, result_i, store_data_i;
    logic [4:0]  wb_addr_i;
    logic [1:0]  mem_op_i;
    logic [2:0]  funct3_i;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_wstrb_o;
    logic        wb_flag_o, err_o;
    logic [31:0] pc_o, wb_data_o;
    logic [4:0]  wb_addr_o;
    int          n_cmp = 0;
    int          n_bad = 0;

    ysyx_23060072_lsu_stage dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .result_i(result_i),
        .store_data_i(store_data_i), .mem_op_i(mem_op_i), .funct3_i(funct3_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .wb_flag_o(wb_flag_o),
        .pc_o(pc_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rd, input logic [31:0] pc);
        valid_i = 1'b1; mem_op_i = op; funct3_i = f3; result_i = addr;
        store_data_i = data; wb_addr_i = rd; wb_en_i = 1'b1; pc_i = pc;
        tick;
        valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; pc_i = 0; wb_en_i = 1'b0; wb_addr_i = 0; result_i = 0;
        store_data_i = 0; mem_op_i = 0; funct3_i = 0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        mem_rdata_i = 0;
        tick; tick;
        chk("rst_ready", 32'(ready_o), 0);
        chk("rst_req", 32'(mem_req_o), 0);
        chk("rst_flag", 32'(wb_flag_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_wbdata", wb_data_o, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(ready_o), 1);

        // ALU op to x5, then the same op to x0
        issue(2'b00, 3'b000, 32'h1234, 0, 5'd5, 32'h8000_0000);
        chk("alu_flag", 32'(wb_flag_o), 1);
        chk("alu_data", wb_data_o, 32'h1234);
        chk("alu_rd", 32'(wb_addr_o), 5);
        chk("alu_pc", pc_o, 32'h8000_0000);
        chk("alu_ready", 32'(ready_o), 1);
        tick;
        chk("alu_flag_once", 32'(wb_flag_o), 0);
        chk("alu_data_hold", wb_data_o, 32'h1234);
        issue(2'b00, 3'b000, 32'h1234, 0, 5'd0, 32'h8000_0004);
        chk("alu_x0_flag", 32'(wb_flag_o), 0);

        // LB at 0x103, grant two cycles late
        issue(2'b01, 3'b000, 32'h103, 0, 5'd7, 32'h100);
        chk("lb_req", 32'(mem_req_o), 1);
        chk("lb_we", 32'(mem_we_o), 0);
        chk("lb_addr", mem_addr_o, 32'h100);
        chk("lb_wstrb", 32'(mem_wstrb_o), 0);
        chk("lb_busy", 32'(ready_o), 0);
        tick;
        chk("lb_req_hold1", 32'(mem_req_o), 1);
        tick;
        chk("lb_req_hold2", 32'(mem_req_o), 1);
        chk("lb_addr_hold", mem_addr_o, 32'h100);
        mem_gnt_i = 1'b1;
        tick;
        mem_gnt_i = 1'b0;
        chk("lb_req_drop", 32'(mem_req_o), 0);
        chk("lb_wait_busy", 32'(ready_o), 0);
        chk("lb_no_early_flag", 32'(wb_flag_o), 0);
        mem_rdata_i = 32'h80FF_FFFF; mem_rvalid_i = 1'b1;
        tick;
        mem_rvalid_i = 1'b0;
        chk("lb_flag", 32'(wb_flag_o), 1);
        chk("lb_data", wb_data_o, 32'hFFFF_FF80);
        chk("lb_rd", 32'(wb_addr_o), 7);
        chk("lb_pc", pc_o, 32'h100);
        chk("lb_ready", 32'(ready_o), 1);
        tick;
        chk("lb_flag_once", 32'(wb_flag_o), 0);

        // LHU at 0x102, immediate grant
        issue(2'b01, 3'b101, 32'h102, 0, 5'd9, 32'h104);
        chk("lhu_addr", mem_addr_o, 32'h100);
        mem_gnt_i = 1'b1;
        tick;
        mem_gnt_i = 1'b0;
        mem_rdata_i = 32'h8001_ABCD; mem_rvalid_i = 1'b1;
        tick;
        mem_rvalid_i = 1'b0;
        chk("lhu_flag", 32'(wb_flag_o), 1);
        chk("lhu_data", wb_data_o, 32'h0000_8001);

        // SB at 0x201: posted write, no write-back
        issue(2'b10, 3'b000, 32'h201, 32'hAABB_CCDD, 5'd0, 32'h108);
        chk("sb_req", 32'(mem_req_o), 1);
        chk("sb_we", 32'(mem_we_o), 1);
        chk("sb_addr", mem_addr_o, 32'h200);
        chk("sb_wstrb", 32'(mem_wstrb_o), 32'h2);
        chk("sb_wdata", mem_wdata_o, 32'hDDDD_DDDD);
        mem_gnt_i = 1'b1;
        tick;
        mem_gnt_i = 1'b0;
        chk("sb_req_drop", 32'(mem_req_o), 0);
        chk("sb_ready", 32'(ready_o), 1);
        chk("sb_no_flag", 32'(wb_flag_o), 0);
        chk("sb_wbdata_hold", wb_data_o, 32'h0000_8001);

        // SH at 0x202 uses the upper lanes
        issue(2'b10, 3'b001, 32'h202, 32'h1234_5678, 5'd0, 32'h10C);
        chk("sh_wstrb", 32'(mem_wstrb_o), 32'hC);
        chk("sh_wdata", mem_wdata_o, 32'h5678_5678);
        mem_gnt_i = 1'b1;
        tick;
        mem_gnt_i = 1'b0;

        // misaligned LW, then an ALU op accepted straight away
        issue(2'b01, 3'b010, 32'h102, 0, 5'd3, 32'h110);
        chk("lw_mis_err", 32'(err_o), 1);
        chk("lw_mis_req", 32'(mem_req_o), 0);
        chk("lw_mis_flag", 32'(wb_flag_o), 0);
        chk("lw_mis_ready", 32'(ready_o), 1);
        issue(2'b00, 3'b000, 32'hABCD, 0, 5'd3, 32'h114);
        chk("after_err_clear", 32'(err_o), 0);
        chk("after_err_flag", 32'(wb_flag_o), 1);
        chk("after_err_data", wb_data_o, 32'hABCD);

        // illegal encodings
        issue(2'b11, 3'b000, 32'h0, 0, 5'd3, 32'h118);
        chk("op11_err", 32'(err_o), 1);
        chk("op11_req", 32'(mem_req_o), 0);
        issue(2'b10, 3'b100, 32'h0, 0, 5'd0, 32'h11C);
        chk("sbu_err", 32'(err_o), 1);
        issue(2'b01, 3'b001, 32'h101, 0, 5'd3, 32'h120);
        chk("lh_mis_err", 32'(err_o), 1);
        tick;
        chk("err_once", 32'(err_o), 0);

        // reset while waiting for read data
        issue(2'b01, 3'b010, 32'h300, 0, 5'd4, 32'h124);
        mem_gnt_i = 1'b1;
        tick;
        mem_gnt_i = 1'b0;
        chk("wait_busy", 32'(ready_o), 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("rst_wait_ready", 32'(ready_o), 1);
        chk("rst_wait_req", 32'(mem_req_o), 0);
        chk("rst_wait_data", wb_data_o, 0);
        mem_rdata_i = 32'hDEAD_BEEF; mem_rvalid_i = 1'b1;
        tick;
        mem_rvalid_i = 1'b0;
        chk("stale_rvalid_flag", 32'(wb_flag_o), 0);
        chk("stale_rvalid_data", wb_data_o, 0);
        chk("stale_rvalid_ready", 32'(ready_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
